// File: rtl/disp_sched_pkg.sv
// disp_sched_pkg: shared constants and encodings for the display channel scheduler
package disp_sched_pkg;
  localparam int DISP_NCH = 8;
  localparam int DISP_CW = $clog2(DISP_NCH);
  typedef enum logic [1:0] {IDLE, SEEK, SHOW} state_t;
  typedef enum logic {FWD = 1'b0, BWD = 1'b1} dir_t;
endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: counts shown cycles in auto mode and flags the last one of each dwell
//   clk, RSTN : clock, async active-low reset
//   run       : count this cycle
//   clr       : return to 0 (wins over run)
//   expire    : cnt == DWELL-1
module dwell_timer #(
  parameter int DWELL = 100000000,
  parameter int DW = 27
) (
  input  logic clk,
  input  logic RSTN,
  input  logic run,
  input  logic clr,
  output logic expire
);
  logic [DW-1:0] cnt;
  assign expire = cnt == DW'(DWELL - 1);
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) cnt <= '0;
    else if (clr || (run && expire)) cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
endmodule

// File: rtl/disp_chan_sched.sv
// disp_chan_sched: picks the display channel from force, button steps and auto dwell, skipping disabled channels
//   en_mask              : per-channel enable
//   auto_mode, hold      : timed round-robin and its freeze
//   btn_next, btn_prev   : single-cycle step requests (ignored outside SHOW)
//   force_valid/sel      : jump straight to an enabled channel
//   sel, sel_valid       : chosen channel, valid while showing
//   switch_pulse, busy   : first SHOW cycle strobe, scan in progress
module disp_chan_sched
  import disp_sched_pkg::*;
#(
  parameter int NCH = DISP_NCH,
  parameter int CW = DISP_CW,
  parameter int DWELL = 100000000,
  parameter int DW = 27
) (
  input  logic           clk,
  input  logic           RSTN,
  input  logic [NCH-1:0] en_mask,
  input  logic           auto_mode,
  input  logic           hold,
  input  logic           btn_next,
  input  logic           btn_prev,
  input  logic           force_valid,
  input  logic [CW-1:0]  force_sel,
  output logic [CW-1:0]  sel,
  output logic           sel_valid,
  output logic           switch_pulse,
  output logic           busy
);
  state_t state, state_nx;
  dir_t dir, dir_nx;
  logic [CW-1:0] cand, cand_nx, sel_nx, steps, steps_nx;
  logic pulse_nx, expire, run, clr;
  assign run = (state == SHOW) && auto_mode && !hold;
  // a fresh SHOW entry restarts the dwell even when re-entering SHOW via force
  assign clr = (state != SHOW) || !auto_mode || pulse_nx;
  dwell_timer #(.DWELL(DWELL), .DW(DW)) u_dwell (
    .clk(clk), .RSTN(RSTN), .run(run), .clr(clr), .expire(expire)
  );
  always_ff @(posedge clk or negedge RSTN)
    if (!RSTN) begin
      state <= IDLE;
      dir <= FWD;
      cand <= '0;
      steps <= '0;
      sel <= '0;
      switch_pulse <= 1'b0;
    end else begin
      state <= state_nx;
      dir <= dir_nx;
      cand <= cand_nx;
      steps <= steps_nx;
      sel <= sel_nx;
      switch_pulse <= pulse_nx;
    end
  always_comb begin
    state_nx = state;
    dir_nx = dir;
    cand_nx = cand;
    steps_nx = steps;
    sel_nx = sel;
    pulse_nx = 1'b0;
    if (en_mask == '0) state_nx = IDLE;
    else if (force_valid && en_mask[force_sel]) begin
      state_nx = SHOW;
      sel_nx = force_sel;
      pulse_nx = 1'b1;
    end else
      case (state)
        IDLE: begin
          state_nx = SEEK;
          dir_nx = FWD;
          cand_nx = sel;
          steps_nx = '0;
        end
        SEEK:
          if (en_mask[cand]) begin
            state_nx = SHOW;
            sel_nx = cand;
            pulse_nx = 1'b1;
          end else if (steps == CW'(NCH - 1)) state_nx = IDLE;
          else begin
            cand_nx = (dir == BWD) ? cand - 1'b1 : cand + 1'b1;
            steps_nx = steps + 1'b1;
          end
        SHOW:
          // losing the current channel outranks buttons, which outrank the dwell
          if (!en_mask[sel] || (btn_next ^ btn_prev) || (auto_mode && !hold && expire)) begin
            state_nx = SEEK;
            dir_nx = (en_mask[sel] && btn_prev && !btn_next) ? BWD : FWD;
            cand_nx = (dir_nx == BWD) ? sel - 1'b1 : sel + 1'b1;
            steps_nx = '0;
          end
        default: state_nx = IDLE;
      endcase
  end
  always_comb begin
    sel_valid = state == SHOW;
    busy = state == SEEK;
  end
endmodule

// File: tb/tb_disp_chan_sched.sv
// tb_disp_chan_sched: directed scenarios plus random traffic against a behavioural scheduler model
module tb_disp_chan_sched;
  localparam int NCH = 8;
  localparam int DWELL = 4;
  logic clk = 1'b0;
  logic RSTN = 1'b0;
  logic [7:0] en_mask = '0;
  logic auto_mode = 1'b0, hold = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, force_valid = 1'b0;
  logic [2:0] force_sel = '0;
  logic [2:0] sel;
  logic sel_valid, switch_pulse, busy;
  int checks = 0, failures = 0;
  int m_st, m_sel, m_cand, m_dir, m_left, m_dw;
  bit m_pulse;
  always #5 clk = ~clk;
  disp_chan_sched #(.NCH(8), .CW(3), .DWELL(DWELL), .DW(3)) dut (
    .clk(clk), .RSTN(RSTN), .en_mask(en_mask), .auto_mode(auto_mode), .hold(hold),
    .btn_next(btn_next), .btn_prev(btn_prev), .force_valid(force_valid), .force_sel(force_sel),
    .sel(sel), .sel_valid(sel_valid), .switch_pulse(switch_pulse), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // model: m_st 0=idle 1=scanning 2=showing; m_left = candidate checks still allowed
  task automatic model_reset();
    m_st = 0; m_sel = 0; m_cand = 0; m_dir = 1; m_left = 0; m_dw = 0; m_pulse = 0;
  endtask
  task automatic m_enter(input int c);
    m_st = 2; m_sel = c; m_pulse = 1; m_dw = 0;
  endtask
  task automatic m_seek(input int d);
    m_st = 1; m_dir = d; m_cand = (m_sel + d + NCH) % NCH; m_left = NCH;
  endtask
  task automatic model_step();
    bit pv, nx, ex;
    pv = btn_prev && !btn_next;
    nx = btn_next && !btn_prev;
    ex = auto_mode && !hold && (m_dw == DWELL - 1);
    m_pulse = 0;
    if (en_mask == 0) m_st = 0;
    else if (force_valid && en_mask[force_sel]) m_enter(int'(force_sel));
    else if (m_st == 0) begin
      m_st = 1; m_cand = m_sel; m_dir = 1; m_left = NCH;
    end else if (m_st == 1) begin
      if (en_mask[m_cand]) m_enter(m_cand);
      else if (m_left == 1) m_st = 0;
      else begin
        m_cand = (m_cand + m_dir + NCH) % NCH;
        m_left--;
      end
    end else if (!en_mask[m_sel]) m_seek(1);
    else if (pv) m_seek(-1);
    else if (nx || ex) m_seek(1);
    else m_dw = auto_mode ? m_dw + (hold ? 0 : 1) : 0;
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("cyc", {sel, sel_valid, busy, switch_pulse}, {m_sel[2:0], m_st == 2, m_st == 1, m_pulse});
  endtask
  task automatic run_until_pulse(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!switch_pulse && n < max);
    if (!switch_pulse) chk("pulse_timeout", 0, 1);
  endtask
  initial begin
    int n, tot;
    model_reset();
    repeat (2) @(posedge clk);
    #1 chk("rst", {sel, sel_valid, busy, switch_pulse}, 0);
    @(negedge clk) RSTN = 1'b1;
    en_mask = 8'h01;
    step(); chk("seek1", busy, 1);
    step(); chk("show1", {sel, sel_valid, switch_pulse}, {3'd0, 1'b1, 1'b1});
    step(); chk("pulse_once", switch_pulse, 0);
    en_mask = 8'h25; auto_mode = 1'b1;
    run_until_pulse(40, n); chk("auto_a", sel, 2);
    run_until_pulse(40, n); chk("auto_b", sel, 5); chk("auto_b_n", n, 7);
    run_until_pulse(40, n); chk("auto_c", sel, 0); chk("auto_c_n", n, 7);
    run_until_pulse(40, n); chk("auto_d", sel, 2); chk("auto_d_n", n, 6);
    step();
    hold = 1'b1;
    repeat (10) step();
    hold = 1'b0;
    run_until_pulse(40, n); tot = n + 11;
    chk("hold_sel", sel, 5); chk("hold_n", tot, 17);
    auto_mode = 1'b0;
    en_mask = 8'h81; force_valid = 1'b1; force_sel = 3'd0;
    step(); force_valid = 1'b0;
    chk("force0", {sel, sel_valid, switch_pulse}, {3'd0, 1'b1, 1'b1});
    btn_prev = 1'b1; step(); btn_prev = 1'b0;
    chk("prev_seek", busy, 1);
    step(); chk("prev_wrap", {sel, sel_valid, switch_pulse}, {3'd7, 1'b1, 1'b1});
    btn_prev = 1'b1; btn_next = 1'b1; step(); btn_prev = 1'b0; btn_next = 1'b0;
    chk("both_btn", {sel, sel_valid, busy}, {3'd7, 1'b1, 1'b0});
    step();
    en_mask = 8'h08; step(); chk("seek_f", busy, 1);
    force_valid = 1'b1; force_sel = 3'd4; step();
    chk("force_dis", {sel_valid, busy}, 2'b01);
    force_sel = 3'd3; step(); force_valid = 1'b0;
    chk("force_seek", {sel, sel_valid, switch_pulse}, {3'd3, 1'b1, 1'b1});
    en_mask = 8'h44; force_valid = 1'b1; force_sel = 3'd2; step(); force_valid = 1'b0;
    chk("force2", sel, 2);
    en_mask = 8'h40;
    run_until_pulse(20, n); chk("drop_sel", sel, 6);
    en_mask = 8'h00; step();
    chk("mask0", {sel, sel_valid, busy}, {3'd6, 1'b0, 1'b0});
    en_mask = 8'h10; step(); step(); chk("pre_arst", busy, 1);
    #3 RSTN = 1'b0;
    #1 chk("arst", {sel, sel_valid, busy, switch_pulse}, 0);
    model_reset();
    @(negedge clk) RSTN = 1'b1;
    run_until_pulse(20, n); chk("post_rst_sel", sel, 4);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0)
        case ($urandom_range(3))
          0: en_mask = 8'(1 << $urandom_range(7));
          1: en_mask = 8'($urandom);
          2: en_mask = 8'($urandom) & 8'($urandom);
          default: en_mask = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
        endcase
      if ($urandom_range(63) == 0) auto_mode = ~auto_mode;
      hold = $urandom_range(3) == 0;
      btn_next = $urandom_range(9) == 0;
      btn_prev = $urandom_range(9) == 0;
      force_valid = $urandom_range(19) == 0;
      force_sel = 3'($urandom_range(7));
      step();
      btn_next = 1'b0; btn_prev = 1'b0; force_valid = 1'b0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
